// File: rtl/rmii_frame_rx.sv
// rmii_frame_rx: RMII receive front end. Samples CRS_DV/RXD, merges the
// end-of-frame CRS_DV toggling back into one carrier, locks on preamble + SFD
// and streams the frame body (MAC dst .. FCS) as a gap-free dibit stream.
// outclk stays high for the whole body and done marks the last dibit. An
// outclk drop before done is an abort.
module rmii_frame_rx #(
  parameter int PREAMBLE_MIN_DIBITS = 8,
  parameter int MAX_FRAME_DIBITS    = 6088
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       crs_dv,
  input  logic [1:0] rxd,
  output logic       outclk,
  output logic [1:0] out,
  output logic       done,
  output logic       err,
  output logic       busy
);

  localparam int PW = $clog2(PREAMBLE_MIN_DIBITS + 1);
  localparam int DW = $clog2(MAX_FRAME_DIBITS + 1);

  localparam logic [PW-1:0] PCNT_ONE = PW'(1);
  localparam logic [PW-1:0] PCNT_MIN = PW'(PREAMBLE_MIN_DIBITS);
  localparam logic [DW-1:0] DCNT_ONE = DW'(1);
  localparam logic [DW-1:0] DCNT_MAX = DW'(MAX_FRAME_DIBITS);

  typedef enum logic [2:0] {
    ST_WAIT_IDLE = 3'd0,
    ST_IDLE      = 3'd1,
    ST_PREAMBLE  = 3'd2,
    ST_DATA      = 3'd3,
    ST_DISCARD   = 3'd4
  } state_t;

  state_t          state_r, state_nxt;
  logic [1:0]      a_d_r;
  logic            a_dv_r;
  logic            s_vld_s;
  logic [PW-1:0]   pcnt_r, pcnt_nxt;
  logic [DW-1:0]   dcnt_r, dcnt_nxt;
  logic [1:0]      pend_r, pend_nxt;
  logic            pend_vld_r, pend_vld_nxt;
  logic [1:0]      out_nxt;
  logic            outclk_nxt, done_nxt, err_nxt, busy_nxt;

  // A dibit is valid if CRS_DV was high with it or on the following cycle;
  // this bridges the single-cycle lows of end-of-frame CRS_DV toggling.
  assign s_vld_s = a_dv_r || crs_dv;

  // Input stage: one-cycle delay so the next CRS_DV can qualify this dibit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_d_r  <= 2'b00;
      a_dv_r <= 1'b0;
    end else begin
      a_d_r  <= rxd;
      a_dv_r <= crs_dv;
    end
  end

  // State register; reset lands in WAIT_IDLE so we never lock mid-frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_WAIT_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_WAIT_IDLE: begin
        if (!s_vld_s) state_nxt = ST_IDLE;
        else          state_nxt = ST_WAIT_IDLE;
      end
      ST_IDLE: begin
        if (s_vld_s && (a_d_r == 2'b01)) state_nxt = ST_PREAMBLE;
        else                             state_nxt = ST_IDLE;
      end
      ST_PREAMBLE: begin
        if (!s_vld_s)                                       state_nxt = ST_IDLE;
        else if (a_d_r == 2'b01)                            state_nxt = ST_PREAMBLE;
        else if ((a_d_r == 2'b11) && (pcnt_r >= PCNT_MIN)) state_nxt = ST_DATA;
        else                                                state_nxt = ST_DISCARD;
      end
      ST_DATA: begin
        if (!s_vld_s)                state_nxt = ST_IDLE;
        else if (dcnt_r == DCNT_MAX) state_nxt = ST_DISCARD;
        else                         state_nxt = ST_DATA;
      end
      ST_DISCARD: begin
        if (!s_vld_s) state_nxt = ST_IDLE;
        else          state_nxt = ST_DISCARD;
      end
      default: state_nxt = ST_WAIT_IDLE;
    endcase
  end

  // Output/datapath next values. One dibit is held back in pend so that the
  // last body dibit can be flagged with done once carrier end is seen.
  always_comb begin
    pcnt_nxt     = pcnt_r;
    dcnt_nxt     = dcnt_r;
    pend_nxt     = pend_r;
    pend_vld_nxt = pend_vld_r;
    out_nxt      = out;
    outclk_nxt   = 1'b0;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    busy_nxt     = busy;
    case (state_r)
      ST_IDLE: begin
        if (s_vld_s && (a_d_r == 2'b01)) pcnt_nxt = PCNT_ONE;
        else                             pcnt_nxt = pcnt_r;
      end
      ST_PREAMBLE: begin
        if (!s_vld_s) begin
          pcnt_nxt = pcnt_r;
        end else if (a_d_r == 2'b01) begin
          if (pcnt_r >= PCNT_MIN) pcnt_nxt = pcnt_r;
          else                    pcnt_nxt = pcnt_r + PCNT_ONE;
        end else if ((a_d_r == 2'b11) && (pcnt_r >= PCNT_MIN)) begin
          dcnt_nxt     = {DW{1'b0}};
          pend_vld_nxt = 1'b0;
          busy_nxt     = 1'b1;
        end else begin
          err_nxt = 1'b1;
        end
      end
      ST_DATA: begin
        if (s_vld_s) begin
          if (dcnt_r == DCNT_MAX) begin
            // Body too long: abort by letting outclk fall without done.
            err_nxt      = 1'b1;
            pend_vld_nxt = 1'b0;
            busy_nxt     = 1'b0;
          end else begin
            pend_nxt     = a_d_r;
            pend_vld_nxt = 1'b1;
            dcnt_nxt     = dcnt_r + DCNT_ONE;
            if (pend_vld_r) begin
              out_nxt    = pend_r;
              outclk_nxt = 1'b1;
            end else begin
              outclk_nxt = 1'b0;
            end
          end
        end else begin
          if (pend_vld_r) begin
            out_nxt    = pend_r;
            outclk_nxt = 1'b1;
            done_nxt   = 1'b1;
            err_nxt    = (dcnt_r[1:0] != 2'b00);
          end else begin
            err_nxt = 1'b1;
          end
          busy_nxt     = 1'b0;
          pend_vld_nxt = 1'b0;
        end
      end
      ST_WAIT_IDLE, ST_DISCARD: begin
        pend_vld_nxt = 1'b0;
      end
      default: begin
        busy_nxt = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pcnt_r     <= {PW{1'b0}};
      dcnt_r     <= {DW{1'b0}};
      pend_r     <= 2'b00;
      pend_vld_r <= 1'b0;
      out        <= 2'b00;
      outclk     <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      pcnt_r     <= pcnt_nxt;
      dcnt_r     <= dcnt_nxt;
      pend_r     <= pend_nxt;
      pend_vld_r <= pend_vld_nxt;
      out        <= out_nxt;
      outclk     <= outclk_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_rmii_frame_rx.sv
// tb_rmii_frame_rx: directed frames into rmii_frame_rx; a negedge monitor
// logs outclk/out/done/err/busy events and the main sequence compares the
// per-frame deltas against hand-derived expectations.
module tb_rmii_frame_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       crs_dv;
  logic [1:0] rxd;
  logic       outclk;
  logic [1:0] out;
  logic       done;
  logic       err;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // monitor state (written only by the monitor)
  int   oc_total = 0, rise_total = 0, done_total = 0, done_oc_total = 0;
  int   err_total = 0, err_done_total = 0, busy_rise_total = 0;
  int   done_idx = 0, err_cyc = 0, rise_cyc = 0, last_oc_cyc = 0, busy_fall_cyc = 0;
  logic prev_outclk = 1'b0, prev_busy = 1'b0;
  logic [1:0] out_log [0:32767];

  // bench state (written only by the main sequence)
  logic [1:0] sent [0:8191];
  int sfd_cyc = 0, data0_cyc = 0;
  int s_oc, s_rise, s_done, s_doneoc, s_err, s_errdone, s_brise;

  rmii_frame_rx dut (
    .clk    (clk),
    .rst    (rst),
    .crs_dv (crs_dv),
    .rxd    (rxd),
    .outclk (outclk),
    .out    (out),
    .done   (done),
    .err    (err),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge.
  always @(negedge clk) begin
    prev_outclk <= outclk;
    prev_busy   <= busy;
    if (outclk === 1'b1) begin
      out_log[oc_total] <= out;
      oc_total    <= oc_total + 1;
      last_oc_cyc <= cyc;
      if (prev_outclk !== 1'b1) begin
        rise_total <= rise_total + 1;
        rise_cyc   <= cyc;
      end
      if (done === 1'b1) begin
        done_oc_total <= done_oc_total + 1;
        done_idx      <= oc_total + 1;
      end
    end
    if (done === 1'b1) done_total <= done_total + 1;
    if (err === 1'b1) begin
      err_total <= err_total + 1;
      err_cyc   <= cyc;
      if (done === 1'b1) err_done_total <= err_done_total + 1;
    end
    if ((busy === 1'b1) && (prev_busy !== 1'b1)) busy_rise_total <= busy_rise_total + 1;
    if ((busy !== 1'b1) && (prev_busy === 1'b1)) busy_fall_cyc <= cyc;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] pat(input int i);
    int v;
    v = i * 3 + i / 7 + 1;
    return v[1:0];
  endfunction

  task automatic drive(input logic dv, input logic [1:0] d);
    @(posedge clk);
    #1;
    crs_dv = dv;
    rxd    = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 2'b00);
  endtask

  task automatic snap();
    s_oc      = oc_total;
    s_rise    = rise_total;
    s_done    = done_total;
    s_doneoc  = done_oc_total;
    s_err     = err_total;
    s_errdone = err_done_total;
    s_brise   = busy_rise_total;
  endtask

  // npre x 01, SFD, ndata body dibits; tail=1 toggles CRS_DV on the last 8.
  task automatic send_frame(input int npre, input int ndata, input bit tail);
    for (int i = 0; i < npre; i++) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    sfd_cyc = cyc;
    for (int i = 0; i < ndata; i++) begin
      logic dv;
      sent[i] = pat(i);
      dv = 1'b1;
      if (tail && (i >= ndata - 8)) dv = (((i - (ndata - 8)) % 2) == 1);
      drive(dv, sent[i]);
      if (i == 0) data0_cyc = cyc;
    end
    idle(6);
  endtask

  task automatic check_frame(input string tag, input int e_oc, input int e_done, input int e_err);
    check({tag, "_outclk_cnt"},  oc_total - s_oc, e_oc);
    check({tag, "_done_cnt"},    done_total - s_done, e_done);
    check({tag, "_done_outclk"}, done_oc_total - s_doneoc, e_done);
    check({tag, "_err_cnt"},     err_total - s_err, e_err);
    check({tag, "_busy_end"},    {31'd0, busy}, 32'd0);
  endtask

  task automatic check_data(input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (out_log[s_oc + i] !== sent[i]) bad++;
    end
    check(tag, bad, 0);
  endtask

  initial begin
    rst    = 1'b0;
    crs_dv = 1'b0;
    rxd    = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outclk", {31'd0, outclk}, 32'd0);
    check("reset_out",    {30'd0, out},    32'd0);
    check("reset_done",   {31'd0, done},   32'd0);
    check("reset_err",    {31'd0, err},    32'd0);
    check("reset_busy",   {31'd0, busy},   32'd0);
    rst = 1'b1;
    idle(6);

    // nominal 64-byte frame, toggling CRS_DV tail
    snap();
    send_frame(31, 256, 1'b1);
    check_frame("nominal", 256, 1, 0);
    check_data("nominal_data", 256);
    check("nominal_contiguous", rise_total - s_rise, 1);
    check("nominal_done_index", done_idx - s_oc, 256);
    check("nominal_latency", rise_cyc - data0_cyc, 3);
    check("nominal_busy_rise", busy_rise_total - s_brise, 1);
    check("nominal_busy_fall", busy_fall_cyc - last_oc_cyc, 0);

    // short preambles
    snap();
    send_frame(4, 16, 1'b0);
    check_frame("short4", 0, 0, 1);
    check("short4_err_timing", err_cyc - sfd_cyc, 2);
    snap();
    send_frame(7, 16, 1'b0);
    check_frame("short7", 0, 0, 1);

    // exactly minimum preamble
    snap();
    send_frame(8, 64, 1'b0);
    check_frame("min_pre", 64, 1, 0);
    check_data("min_pre_data", 64);
    check("min_pre_contiguous", rise_total - s_rise, 1);

    // bad preamble dibit
    snap();
    repeat (10) drive(1'b1, 2'b01);
    drive(1'b1, 2'b10);
    repeat (10) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    for (int i = 0; i < 16; i++) drive(1'b1, pat(i));
    idle(6);
    check_frame("bad_pre", 0, 0, 1);
    snap();
    send_frame(12, 32, 1'b0);
    check_frame("after_bad", 32, 1, 0);
    check_data("after_bad_data", 32);

    // oversize frame
    snap();
    send_frame(8, 6100, 1'b0);
    check_frame("oversize", 6087, 0, 1);
    check_data("oversize_data", 6087);
    check("oversize_contiguous", rise_total - s_rise, 1);
    check("oversize_busy_fall", busy_fall_cyc - last_oc_cyc, 1);

    // exactly maximum length
    snap();
    send_frame(8, 6088, 1'b0);
    check_frame("max_len", 6088, 1, 0);

    // misaligned and empty
    snap();
    send_frame(8, 257, 1'b0);
    check_frame("misaligned", 257, 1, 1);
    check("misaligned_err_with_done", err_done_total - s_errdone, 1);
    check("misaligned_done_index", done_idx - s_oc, 257);
    snap();
    send_frame(8, 0, 1'b0);
    check_frame("empty", 0, 0, 1);

    // reset in the middle of a frame
    repeat (8) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    for (int i = 0; i < 99; i++) drive(1'b1, pat(i));
    @(negedge clk);
    check("midrst_before_outclk", {31'd0, outclk}, 32'd1);
    rst = 1'b0;
    drive(1'b1, pat(99));
    @(negedge clk);
    check("midrst_outclk", {31'd0, outclk}, 32'd0);
    check("midrst_busy",   {31'd0, busy},   32'd0);
    check("midrst_out",    {30'd0, out},    32'd0);
    rst = 1'b1;
    snap();
    for (int i = 100; i < 200; i++) drive(1'b1, pat(i));
    idle(6);
    check_frame("midrst_rest", 0, 0, 0);
    snap();
    send_frame(8, 64, 1'b0);
    check_frame("post_rst", 64, 1, 0);
    check_data("post_rst_data", 64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rmii_frame_rx.md
Name: rmii_frame_rx

Overview:
- Receive front end between the RMII PHY pins and the Ethernet frame parser.
- Samples CRS_DV/RXD and undoes RMII end-of-frame CRS_DV toggling.
- Locks on preamble + SFD, then emits the frame body (MAC dst through FCS) as a gap-free dibit stream, LSB-first, with outclk held high for the whole frame and done on the last dibit.
- Signals aborts by dropping outclk mid-frame, which the downstream parser treats as a frame reset.

Parameters:
- PREAMBLE_MIN_DIBITS, 8: minimum count of 01 dibits before the SFD 11 for the frame to be accepted.
- MAX_FRAME_DIBITS, 6088: maximum body length in dibits (1522 bytes × 4); longer frames are aborted.

Ports:
- clk  in  1  50 MHz RMII reference clock.
- rst  in  1  synchronous, active-low reset (rst==0 resets).
- crs_dv  in  1  RMII carrier sense / data valid.
- rxd  in  2  RMII receive dibit.
- outclk  out  1  valid strobe for out; continuous for the whole frame body.
- out  out  2  body dibit.
- done  out  1  high together with outclk on the final body dibit.
- err  out  1  one-cycle error pulse.
- busy  out  1  high from SFD acceptance until done or abort.

Behaviour:
- Reset:
  - Applies when rst==0 at a clk edge.
  - Next cycle: outclk=0, out=0, done=0, err=0, busy=0, pend_vld=0, counters=0, state=WAIT_IDLE.
  - Reset mid-frame drops outclk immediately; the rest of that frame is ignored.
- Stage A:
  - Every cycle registers a_d<=rxd and a_dv<=crs_dv.
  - Sample validity: s_vld = a_dv || crs_dv. A single low CRS_DV cycle inside the frame still carries data; two consecutive lows mean carrier end.
  - All state decisions use a_d and s_vld.
- States:
  - WAIT_IDLE: goes to IDLE on the first cycle with !s_vld. This prevents locking mid-frame after reset.
  - IDLE:
    - s_vld && a_d==01: PREAMBLE, pcnt=1.
    - 00 and 10 are ignored.
  - PREAMBLE:
    - !s_vld: IDLE silently.
    - a_d==01: pcnt++, saturating at PREAMBLE_MIN_DIBITS.
    - a_d==11 with pcnt>=PREAMBLE_MIN_DIBITS: DATA, dcnt=0, busy<=1.
    - a_d==11 with pcnt short, or a_d==00, or a_d==10: err pulse, go to DISCARD.
  - DATA, when s_vld:
    - pend<=a_d, pend_vld<=1, dcnt++.
    - If pend_vld was already set: out<=pend, outclk<=1.
    - If dcnt reaches MAX_FRAME_DIBITS while still valid: outclk<=0 next cycle, no done, err pulse, pend_vld<=0, busy<=0, go to DISCARD.
  - DATA, when !s_vld (frame end):
    - If pend_vld: out<=pend, outclk<=1, done<=1.
    - If dcnt%4!=0 (misaligned), err pulses the same cycle as done.
    - If pend_vld==0 (SFD then immediate carrier loss): err pulse only.
    - In all cases: busy<=0, pend_vld<=0, go to IDLE.
  - DISCARD: stays until !s_vld, then goes to IDLE.
- Outputs:
  - out, outclk, done and err are registered.
  - Latency: rxd at pins in cycle t appears on out at cycle t+3.
  - outclk never has a gap inside a frame. Any outclk drop before done is an abort.
- Between frames: outclk is low for at least 2 cycles, because a new frame needs a preamble.
- Simultaneous events: reset has priority over everything; the length abort has priority over the end check in the same cycle.
- Counters:
  - pcnt width is clog2(PREAMBLE_MIN_DIBITS+1).
  - dcnt width is clog2(MAX_FRAME_DIBITS+1).

Test Plan:
- Nominal frame: 31×01 + 11, then 64 bytes (256 dibits, crs_dv steady, then toggling 0/1 for the last 8 dibits, then low) -> exactly 256 outclk cycles, contiguous; out matches input dibits; done on the 256th; err never high.
- Short preamble: 4×01 + 11 + data -> err pulse 2 cycles after the SFD dibit; no outclk for the frame; next valid frame received normally.
- Bad preamble dibit: 10×01, 10, 01… -> err pulse, no outclk until carrier drops and a clean frame follows.
- Oversize: valid preamble + 6100 data dibits -> 6087 outclk cycles, outclk drops, err pulses, no done; busy falls.
- Misaligned / empty: 257 data dibits -> done on the 257th with err the same cycle; SFD then carrier drop -> err only, no outclk.
- Reset: rst=0 at data dibit 100 with carrier still high -> outclk=0 next cycle; the rest of the frame is ignored; the next frame after a carrier gap is received intact.
